sharpen_window_feeder: RTL and testbench

//  Upstream feeder for the 4-pixel sharpen datapath. Accepts a raster-order stream of packed 32-bit pixel words
//  (4 x 8-bit, MSB byte = leftmost pixel) and presents, per word, the vertically aligned triple {up, mid, down}.

---
 rtl/sharpen_window_feeder_pkg.sv | 22 ++
 rtl/sharpen_line_buffer.sv | 33 +++
 rtl/sharpen_window_feeder.sv | 192 +++++++++++++++++++
 tb/tb_sharpen_window_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sharpen_window_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sharpen_window_feeder_pkg
// Brief   : Shared widths and feeder state encodings for the sharpen window feeder.
// Revision: 1.0
// ============================================================================
package sharpen_window_feeder_pkg;

    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/sharpen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : sharpen_line_buffer
// Brief   : One image row of 32-bit words; single write port, async read by column.
// Revision: 1.0
// ============================================================================
module sharpen_line_buffer
    import sharpen_window_feeder_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    // Storage is rounded up to a power of two so any address value is a legal index.
    logic [WORD_W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sharpen_window_feeder.sv
`default_nettype none
// ============================================================================
// Module  : sharpen_window_feeder
// Brief   : Turns a raster word stream into vertically aligned {up,mid,down}
//           triples with reflected top/bottom rows.
// Revision: 1.0
// ============================================================================
module sharpen_window_feeder
    import sharpen_window_feeder_pkg::*;
#(
    parameter  int ROW_WORDS = 16,
    parameter  int NUM_ROWS  = 16,
    localparam int COL_W     = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1,
    localparam int ROW_W     = $clog2(NUM_ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_up,
    output logic [WORD_W-1:0] out_mid,
    output logic [WORD_W-1:0] out_down,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              busy,
    output logic              done
);

    localparam logic [COL_W-1:0] c_col_last = COL_W'(ROW_WORDS - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(NUM_ROWS - 1);

    feeder_state_e     r_state, w_state_nxt;
    logic [COL_W-1:0]  r_col, w_col_nxt;
    logic [ROW_W-1:0]  r_row, w_row_nxt;
    logic              r_flushed, w_flushed_nxt;

    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_up, r_out_mid, r_out_down;
    logic [ROW_W-1:0]  r_out_row;
    logic [COL_W-1:0]  r_out_col;

    logic [WORD_W-1:0] w_prev_rd, w_cur_rd;
    logic              w_out_free, w_in_fire, w_load_stream, w_load_flush, w_first_row;

    assign w_out_free    = !r_out_valid || out_ready;
    assign w_in_fire     = in_valid && in_ready;
    assign w_load_stream = (r_state == ST_STREAM) && w_in_fire;
    assign w_load_flush  = (r_state == ST_FLUSH) && !r_flushed && w_out_free;
    assign w_first_row   = (r_row == ROW_W'(1));

    sharpen_line_buffer #(.DEPTH(ROW_WORDS)) u_prev (
        .clk     (clk),
        .i_we    (w_load_stream),
        .i_waddr (r_col),
        .i_wdata (w_cur_rd),
        .i_raddr (r_col),
        .o_rdata (w_prev_rd)
    );

    sharpen_line_buffer #(.DEPTH(ROW_WORDS)) u_cur (
        .clk     (clk),
        .i_we    (w_in_fire),
        .i_waddr (r_col),
        .i_wdata (in_word),
        .i_raddr (r_col),
        .o_rdata (w_cur_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_flushed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_flushed <= w_flushed_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_flushed_nxt = r_flushed;
        in_ready      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt   = ST_FILL;
                    w_col_nxt     = '0;
                    w_row_nxt     = '0;
                    w_flushed_nxt = 1'b0;
                end
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (r_col == c_col_last) begin
                        w_state_nxt = ST_STREAM;
                        w_col_nxt   = '0;
                        w_row_nxt   = ROW_W'(1);
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                in_ready = w_out_free;
                if (in_valid && w_out_free) begin
                    if (r_col == c_col_last) begin
                        w_col_nxt = '0;
                        if (r_row == c_row_last) begin
                            w_state_nxt = ST_FLUSH;
                        end else begin
                            w_row_nxt = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // Last row is re-emitted from the buffers; leave only once the final triple is taken.
                if (!r_flushed) begin
                    if (w_out_free) begin
                        if (r_col == c_col_last) begin
                            w_flushed_nxt = 1'b1;
                        end else begin
                            w_col_nxt = r_col + COL_W'(1);
                        end
                    end
                end else if (w_out_free) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_up    <= '0;
            r_out_mid   <= '0;
            r_out_down  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else if (w_load_stream) begin
            r_out_up    <= w_first_row ? in_word : w_prev_rd;
            r_out_mid   <= w_cur_rd;
            r_out_down  <= in_word;
            r_out_row   <= r_row - ROW_W'(1);
            r_out_col   <= r_col;
            r_out_valid <= 1'b1;
        end else if (w_load_flush) begin
            r_out_up    <= w_prev_rd;
            r_out_mid   <= w_cur_rd;
            r_out_down  <= w_prev_rd;
            r_out_row   <= c_row_last;
            r_out_col   <= r_col;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_up    = r_out_up;
    assign out_mid   = r_out_mid;
    assign out_down  = r_out_down;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;

endmodule
`default_nettype wire

// File: tb/tb_sharpen_window_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sharpen_window_feeder
// Brief   : Randomized bench for two feeder geometries (2x3 and 1x2) against a row-reflection model.
// Revision: 1.0
// ============================================================================
module tb_sharpen_window_feeder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start0, start1, in_valid, out_ready;
    logic [31:0] in_word;

    logic        a_in_ready, a_out_valid, a_busy, a_done;
    logic [31:0] a_up, a_mid, a_down;
    logic [1:0]  a_row;
    logic [0:0]  a_col;
    logic        b_in_ready, b_out_valid, b_busy, b_done;
    logic [31:0] b_up, b_mid, b_down;
    logic [0:0]  b_row;
    logic [0:0]  b_col;

    sharpen_window_feeder #(.ROW_WORDS(2), .NUM_ROWS(3)) u_dut_a (
        .clk(clk), .reset(reset), .start(start0), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_word(in_word), .out_valid(a_out_valid), .out_ready(out_ready), .out_up(a_up),
        .out_mid(a_mid), .out_down(a_down), .out_row(a_row), .out_col(a_col),
        .busy(a_busy), .done(a_done)
    );

    sharpen_window_feeder #(.ROW_WORDS(1), .NUM_ROWS(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_word(in_word), .out_valid(b_out_valid), .out_ready(out_ready), .out_up(b_up),
        .out_mid(b_mid), .out_down(b_down), .out_row(b_row), .out_col(b_col),
        .busy(b_busy), .done(b_done)
    );

    int          sel = 0;
    logic        m_in_ready, m_out_valid, m_busy, m_done;
    logic [31:0] m_up, m_mid, m_down, m_row, m_col;

    always_comb begin
        if (sel == 0) begin
            m_in_ready = a_in_ready; m_out_valid = a_out_valid; m_busy = a_busy; m_done = a_done;
            m_up = a_up; m_mid = a_mid; m_down = a_down; m_row = 32'(a_row); m_col = 32'(a_col);
        end else begin
            m_in_ready = b_in_ready; m_out_valid = b_out_valid; m_busy = b_busy; m_done = b_done;
            m_up = b_up; m_mid = b_mid; m_down = b_down; m_row = 32'(b_row); m_col = 32'(b_col);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_obs();
        return {m_up, m_mid, m_down, m_row[15:0], m_col[15:0]};
    endfunction

    task automatic run_frame(input int s, input int R, input int W,
                             input int p_bub, input int p_stall, input bit poke);
        logic [31:0]  img [4][4];
        logic [127:0] exp_q [$];
        logic [127:0] held;
        bit           held_valid, want_valid, fire;
        int           sent, got, dones, cyc, ur, dr;

        for (int r = 0; r < R; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = $urandom;
        // Reference: missing neighbour row is replaced by the opposite neighbour row.
        for (int r = 0; r < R; r++) begin
            ur = (r == 0) ? 1 : r - 1;
            dr = (r == R - 1) ? R - 2 : r + 1;
            for (int c = 0; c < W; c++)
                exp_q.push_back({img[ur][c], img[r][c], img[dr][c], 16'(r), 16'(c)});
        end

        sel = s;
        @(negedge clk);
        if (s == 0) start0 = 1'b1; else start1 = 1'b1;
        in_valid  = poke;
        in_word   = $urandom;
        out_ready = 1'b1;
        #1;
        check_eq("idle_inready", m_in_ready, 0);
        @(posedge clk); #1;
        check_eq("busy_on", m_busy, 1);

        sent = 0; got = 0; dones = 0; cyc = 0; held_valid = 0; want_valid = 0; held = '0;
        while (dones == 0 && cyc < 2000) begin
            @(negedge clk);
            if (s == 0) start0 = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            else        start1 = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (sent < R * W) begin
                in_valid = ($urandom_range(0, 99) >= p_bub);
                in_word  = img[sent / W][sent % W];
            end else begin
                in_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                in_word  = $urandom;
            end
            out_ready = ($urandom_range(0, 99) >= p_stall);
            #1;
            if (want_valid) check_eq("latency", m_out_valid, 1);
            if (held_valid) begin
                check_eq("stall_valid", m_out_valid, 1);
                check_eq("stall_data", pack_obs(), held);
            end
            if (m_out_valid && !out_ready) check_eq("inready_full", m_in_ready, 0);
            if (m_done) begin
                dones++;
                check_eq("done_outvalid", m_out_valid, 0);
            end
            fire = in_valid && m_in_ready;
            want_valid = fire && (sent >= W);
            if (fire) sent++;
            if (m_out_valid && out_ready) begin
                if (exp_q.size() > 0) check_eq($sformatf("triple%0d", got), pack_obs(), exp_q.pop_front());
                got++;
            end
            held_valid = m_out_valid && !out_ready;
            held       = pack_obs();
            cyc++;
        end
        check_eq("done_seen", dones, 1);

        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        in_valid = poke; out_ready = 1'b1;
        #1;
        check_eq("idle_busy", m_busy, 0);
        check_eq("done_pulse", m_done, 0);
        check_eq("idle_inready2", m_in_ready, 0);
        check_eq("idle_outvalid", m_out_valid, 0);
        check_eq("words_accepted", sent, R * W);
        check_eq("triples_out", got, R * W);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_outvalid", a_out_valid, 0);
        check_eq("rst_inready", a_in_ready, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_data", {a_up, a_mid, a_down, 2'(a_row), 1'(a_col)}, 0);
        check_eq("rst_b", {b_out_valid, b_in_ready, b_busy, b_done}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_frame(0, 3, 2, 0, 0, 0);
        run_frame(0, 3, 2, 0, 50, 0);
        run_frame(0, 3, 2, 40, 0, 0);
        for (int i = 0; i < 4; i++) run_frame(0, 3, 2, 30, 40, 0);
        run_frame(1, 2, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_frame(1, 2, 1, 25, 35, 0);
        run_frame(0, 3, 2, 30, 30, 1);
        run_frame(1, 2, 1, 30, 30, 1);

        // Abort mid-STREAM with a stalled output, then confirm a clean restart.
        sel = 0;
        @(negedge clk);
        start0 = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start0 = 1'b0; in_valid = 1'b1; in_word = 32'h0A0A0A00;
        repeat (3) @(negedge clk);
        #1;
        check_eq("pre_reset_outvalid", a_out_valid, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("abort_outvalid", a_out_valid, 0);
        check_eq("abort_inready", a_in_ready, 0);
        check_eq("abort_busy", a_busy, 0);
        reset = 1'b0; in_valid = 1'b0;
        run_frame(0, 3, 2, 20, 20, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
